// File: rtl/pad_reader_pkg.sv
// Shared types and constants for the NES/SNES pad reader.
package pad_reader_pkg;

   // Poll sequencer states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      WAIT  = 3'd2,
      LOW   = 3'd3,
      HIGH  = 3'd4,
      DONE  = 3'd5
   } pad_state_e;

   // SNES button bit positions within the buttons word
   localparam int unsigned BTN_B      = 0;
   localparam int unsigned BTN_Y      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;
   localparam int unsigned BTN_A      = 8;
   localparam int unsigned BTN_X      = 9;
   localparam int unsigned BTN_L      = 10;
   localparam int unsigned BTN_R      = 11;

   // Larger of two sizing values
   function automatic int unsigned umax(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pad_data_sync.sv
// Two-flop synchronizer for the asynchronous pad data line; resets to 1 (released).
module pad_data_sync (
   input  logic clk,
   input  logic reset,
   input  logic d_in,
   output logic d_sync
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next values: shift the raw line through two stages
   always_comb begin
      meta_d = d_in;
      sync_d = meta_q;
   end

   // Synchronizer stages
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign d_sync = sync_q;

endmodule

// File: rtl/snes_pad_reader.sv
// Console-side NES/SNES pad poller: drives latch/clock, shifts in serial data,
// presents an active-high button word with a one-cycle valid pulse per frame.
// Optional: define PAD_DEBOUNCE_EN to only update buttons when two consecutive
// raw frames agree.
module snes_pad_reader
   import pad_reader_pkg::*;
#(
   parameter int unsigned NUM_BITS     = 16,
   parameter int unsigned LATCH_CYCLES = 144,
   parameter int unsigned HALF_CYCLES  = 36,
   parameter int unsigned GAP_CYCLES   = 200000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                poll_en,
   input  logic                pad_data,
   output logic                pad_latch,
   output logic                pad_clk,
   output logic [NUM_BITS-1:0] buttons,
   output logic                buttons_vld
);

   localparam int unsigned CNT_MAX = umax(umax(LATCH_CYCLES, HALF_CYCLES), GAP_CYCLES);
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam int unsigned BIT_W   = (NUM_BITS < 2) ? 1 : $clog2(NUM_BITS);

   localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(NUM_BITS - 1);

   pad_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [NUM_BITS-1:0] shift_q, shift_d;
   logic                pad_latch_q, pad_latch_d;
   logic                pad_clk_q, pad_clk_d;
   logic [NUM_BITS-1:0] buttons_q, buttons_d;
   logic                buttons_vld_q, buttons_vld_d;
`ifdef PAD_DEBOUNCE_EN
   logic [NUM_BITS-1:0] raw_prev_q, raw_prev_d;
`endif

   logic             data_sync;
   logic             cnt_done;
   logic [BIT_W-1:0] nxt_bit;

   pad_data_sync u_sync (
      .clk    (clk),
      .reset  (reset),
      .d_in   (pad_data),
      .d_sync (data_sync)
   );

   assign cnt_done = (cnt_q == '0);
   assign nxt_bit  = bit_q + BIT_W'(1);

   // Next-state, counter reload, bit capture and registered-output decode
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_done ? cnt_q : (cnt_q - CNT_W'(1));
      bit_d         = bit_q;
      shift_d       = shift_q;
      pad_latch_d   = 1'b0;
      pad_clk_d     = 1'b1;
      buttons_d     = buttons_q;
      buttons_vld_d = 1'b0;
`ifdef PAD_DEBOUNCE_EN
      raw_prev_d    = raw_prev_q;
`endif

      case (state_q)
         IDLE: begin
            // Expired gap holds at zero until polling is enabled
            if (cnt_done && poll_en) begin
               state_d = LATCH;
               cnt_d   = LATCH_LOAD;
               bit_d   = '0;
            end
         end
         LATCH: begin
            if (cnt_done) begin
               state_d = WAIT;
               cnt_d   = HALF_LOAD;
            end
         end
         WAIT: begin
            if (cnt_done) begin
               shift_d[0] = data_sync;
               state_d    = LOW;
               cnt_d      = HALF_LOAD;
            end
         end
         LOW: begin
            if (cnt_done) begin
               state_d = HIGH;
               cnt_d   = HALF_LOAD;
            end
         end
         HIGH: begin
            if (cnt_done) begin
               if (bit_q == LAST_BIT) begin
                  // Final pulse only returns the pad to idle; nothing to sample
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  shift_d[nxt_bit] = data_sync;
                  bit_d            = nxt_bit;
                  state_d          = LOW;
                  cnt_d            = HALF_LOAD;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = GAP_LOAD;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      pad_latch_d = (state_d == LATCH);
      pad_clk_d   = (state_d != LOW);

      if (state_d == DONE) begin
         buttons_vld_d = 1'b1;
`ifdef PAD_DEBOUNCE_EN
         if (shift_q == raw_prev_q) begin
            buttons_d = ~shift_q;
         end
         raw_prev_d = shift_q;
`else
         buttons_d = ~shift_q;
`endif
      end
   end

   // Sequencer and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         bit_q         <= '0;
         shift_q       <= '1;
         pad_latch_q   <= 1'b0;
         pad_clk_q     <= 1'b1;
         buttons_q     <= '0;
         buttons_vld_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_q         <= bit_d;
         shift_q       <= shift_d;
         pad_latch_q   <= pad_latch_d;
         pad_clk_q     <= pad_clk_d;
         buttons_q     <= buttons_d;
         buttons_vld_q <= buttons_vld_d;
      end
   end

`ifdef PAD_DEBOUNCE_EN
   // Previous raw frame for agreement check
   always_ff @(posedge clk) begin
      if (reset) begin
         raw_prev_q <= '1;
      end else begin
         raw_prev_q <= raw_prev_d;
      end
   end
`endif

   assign pad_latch   = pad_latch_q;
   assign pad_clk     = pad_clk_q;
   assign buttons     = buttons_q;
   assign buttons_vld = buttons_vld_q;

endmodule

// File: tb/tb_snes_pad_reader.sv
// Scoreboard bench for snes_pad_reader with a behavioural SNES pad responder.
module tb_snes_pad_reader;

   localparam int unsigned NB = 16;

`ifdef PAD_DEBOUNCE_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          poll_en;
   logic          pad_data;
   logic          pad_latch;
   logic          pad_clk;
   logic [NB-1:0] buttons;
   logic          buttons_vld;

   always #5 clk = ~clk;

   snes_pad_reader #(
      .NUM_BITS     (NB),
      .LATCH_CYCLES (4),
      .HALF_CYCLES  (3),
      .GAP_CYCLES   (10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .poll_en     (poll_en),
      .pad_data    (pad_data),
      .pad_latch   (pad_latch),
      .pad_clk     (pad_clk),
      .buttons     (buttons),
      .buttons_vld (buttons_vld)
   );

   // Pad responder: parallel load on latch, shift on pad_clk rise, 1s fill
   logic [NB-1:0] pad_raw = '1;
   logic [NB-1:0] pad_sr  = '1;
   always @(posedge pad_latch) pad_sr = pad_raw;
   always @(posedge pad_clk) if (!pad_latch) pad_sr = {1'b1, pad_sr[NB-1:1]};
   assign pad_data = pad_sr[0];

   typedef struct {
      string name;
      int    act;
      int    exp;
   } chk_t;

   logic [NB-1:0] exp_q[$];
   chk_t          chk_q[$];

   int  n_checks = 0;
   int  n_fail   = 0;
   int  vld_count = 0;
   bit  gap_chk_en = 1'b0;

   // Monitor-side state
   int  cyc = 0;
   int  frame_start = 0;
   int  vld_cyc = 0;
   int  falls = 0;
   int  latch_len = 0;
   bit  in_frame = 1'b0;
   bit  have_vld = 1'b0;
   logic prev_latch = 1'b0;
   logic prev_clk = 1'b1;

   task automatic compare(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: scoreboard pops on each valid pulse, frame timing checks, queued checks
   always @(negedge clk) begin
      chk_t c;
      cyc++;
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         compare(c.name, c.act, c.exp);
      end
      if (reset) begin
         in_frame  = 1'b0;
         have_vld  = 1'b0;
         latch_len = 0;
         falls     = 0;
      end else begin
         if (pad_latch && !prev_latch) begin
            if (gap_chk_en && have_vld) compare("vld_to_latch", cyc - vld_cyc, 11);
            in_frame    = 1'b1;
            frame_start = cyc;
            falls       = 0;
            latch_len   = 0;
         end
         if (pad_latch) latch_len++;
         if (!pad_latch && prev_latch) compare("latch_len", latch_len, 4);
         if (!pad_clk && prev_clk && in_frame) falls++;
         if (buttons_vld) begin
            if (in_frame) begin
               compare("clk_falls", falls, 16);
               compare("frame_len", cyc - frame_start + 1, 104);
            end
            if (exp_q.size() == 0) compare("unexpected_vld", 1, 0);
            else compare("buttons", int'(buttons), int'(exp_q.pop_front()));
            in_frame = 1'b0;
            vld_cyc  = cyc;
            have_vld = 1'b1;
            vld_count++;
         end
      end
      prev_latch = pad_latch;
      prev_clk   = pad_clk;
   end

   task automatic push_chk(input string nm, input int act, input int exp);
      chk_t c;
      c.name = nm;
      c.act  = act;
      c.exp  = exp;
      chk_q.push_back(c);
   endtask

   task automatic wait_vld(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (buttons_vld) return;
      end
      push_chk("vld_timeout", 0, 1);
   endtask

   task automatic wait_falls(input int n, input int max_cyc);
      int   seen = 0;
      logic pc = pad_clk;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (pc && !pad_clk) seen++;
         pc = pad_clk;
         if (seen == n) return;
      end
      push_chk("falls_timeout", seen, n);
   endtask

   task automatic idle_watch(input int ncyc, output int rises);
      logic pl = pad_latch;
      rises = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (pad_latch && !pl) rises++;
         pl = pad_latch;
      end
   endtask

   task automatic run_frame(input logic [NB-1:0] raw, input logic [NB-1:0] exp_plain,
                            input logic [NB-1:0] exp_db);
      pad_raw = raw;
      exp_q.push_back(DB ? exp_db : exp_plain);
      wait_vld(400);
   endtask

   task automatic check_reset_outputs(input string tag);
      push_chk({tag, "_latch"},   int'(pad_latch),   0);
      push_chk({tag, "_clk"},     int'(pad_clk),     1);
      push_chk({tag, "_buttons"}, int'(buttons),     0);
      push_chk({tag, "_vld"},     int'(buttons_vld), 0);
   endtask

   initial begin
      int rises;
      int vld_before;

      // Reset held 5 cycles
      reset   = 1'b1;
      poll_en = 1'b0;
      repeat (5) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b0;

      // Polling disabled: no frames
      idle_watch(1000, rises);
      push_chk("no_poll_latch", rises, 0);
      push_chk("no_poll_vld", vld_count, 0);

      // Continuous polling, B+A pressed twice (second frame also checks the gap)
      gap_chk_en = 1'b1;
      pad_raw = 16'hFEFE;
      poll_en = 1'b1;
      run_frame(16'hFEFE, 16'h0101, 16'h0000);
      run_frame(16'hFEFE, 16'h0101, 16'h0101);

      // poll_en dropped during bit 5: frame completes, then no more latches
      pad_raw = 16'hFF00;
      exp_q.push_back(DB ? 16'h0101 : 16'h00FF);
      wait_falls(5, 400);
      poll_en    = 1'b0;
      gap_chk_en = 1'b0;
      vld_before = vld_count;
      wait_vld(400);
      idle_watch(300, rises);
      push_chk("drop_vld_count", vld_count - vld_before, 1);
      push_chk("drop_latch", rises, 0);

      // Reset during bit 7: outputs at reset values next cycle, partial frame dropped
      pad_raw = 16'h0000;
      poll_en = 1'b1;
      wait_falls(7, 400);
      reset   = 1'b1;
      poll_en = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      @(negedge clk);
      reset = 1'b0;
      vld_before = vld_count;
      idle_watch(200, rises);
      push_chk("midrst_vld", vld_count - vld_before, 0);
      push_chk("midrst_latch", rises, 0);

      // Debounce-sensitive sequence from a clean reset state
      gap_chk_en = 1'b1;
      poll_en    = 1'b1;
      run_frame(16'hFFFE, 16'h0001, 16'h0000);
      run_frame(16'hFFFD, 16'h0002, 16'h0000);
      run_frame(16'hFFFD, 16'h0002, 16'h0002);
      poll_en = 1'b0;

      // Drain: any frame still pending is a missing valid pulse
      repeat (20) @(negedge clk);
      push_chk("pending_expected", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
